apb_slave_regfile: RTL and testbench
====================================

// Module: apb_slave_regfile
// PURPOSE
//  APB3 completer that terminates the bus driven by the APB master. Holds a small
//  bank of 32-bit registers: reg 0 is CTRL and is exported to downstream logic,
//  the middle regs are RW scratch, and the last reg is a read-only ID.
//  Inserts optional wait states and flags bad accesses on pslverr_o.
// PARAMETERS
//  NUM_REGS     4             register count, >=2; last index is the RO ID register
//  BASE_ADDR    32'h0000_0000 byte address of reg 0
//  ID_VALUE     32'hA9B0_0001 value returned by the ID register
//  WAIT_CYCLES  2             wait states per transfer (used only with APB_SLV_WAIT_EN)
// PORTS
//  clk        in   1   clock, all state on rising edge
//  reset      in   1   asynchronous, active-high reset
//  psel_i     in   1   APB select
//  penable_i  in   1   APB enable (access phase)
//  paddr_i    in   32  byte address
//  pwrite_i   in   1   1=write, 0=read
//  pwdata_i   in   32  write data
//  pready_o   out  1   transfer complete
//  prdata_o   out  32  read data
//  pslverr_o  out  1   error response, valid with pready_o
//  ctrl_o     out  32  current CTRL (reg 0) contents
// BEHAVIOUR
//  Reset: FSM=IDLE, all regs=0, pready_o=0, pslverr_o=0, prdata_o=0, ctrl_o=0.
//  FSM is IDLE -> ACCESS -> IDLE.
//  IDLE: when psel_i=1 and penable_i=0 (setup phase), do the following on that edge:
//   - latch the write flag and wdata;
//   - decode the index as (paddr_i-BASE_ADDR)>>2;
//   - compute err, and load cnt;
//   - go to ACCESS.
//  err = paddr_i[1:0]!=0 | offset>=NUM_REGS*4 | (write & index==NUM_REGS-1).
//  prdata_o is registered on the setup edge:
//   - read & !err: reg[index], or ID_VALUE for the last index;
//   - otherwise 0.
//  prdata_o holds that value until the next setup edge.
//  ACCESS: pready_o = (cnt==0), combinational from state. pslverr_o = pready_o & err.
//  ACCESS with psel_i & penable_i & cnt!=0: cnt decrements.
//  ACCESS with psel_i & penable_i & pready_o:
//   - write & !err: reg[index] <= latched wdata;
//   - next state IDLE.
//  An errored write never modifies any register.
//  Back-to-back transfers: a setup phase in the cycle after completion is accepted
//   from IDLE, so there is no dead cycle beyond the APB setup phase.
//  psel_i dropping while in ACCESS is a protocol abort: go to IDLE, no write,
//   pready_o=0.
//  Reset asserted mid-transfer: immediate return to reset state; a pending write is
//   discarded.
//  ctrl_o = reg[0] directly from the flop, so a write is visible the cycle after
//   completion.
// CONFIGURATION
//  Macro APB_SLV_WAIT_EN.
//  Defined: cnt is loaded with WAIT_CYCLES on the setup edge. pready_o rises after
//   WAIT_CYCLES access cycles, i.e. the transfer is 2+WAIT_CYCLES cycles with setup.
//  Undefined: no counter logic; cnt is constant 0. pready_o is 1 in the first ACCESS
//   cycle, a zero-wait transfer (2 cycles). WAIT_CYCLES is ignored.
// STRUCTURE
//  Package apb_regfile_pkg holds:
//   - state_t enum {IDLE, ACCESS};
//   - APB_ADDR_W/APB_DATA_W=32;
//   - CTRL_IDX=0;
//   - the default ID_VALUE constant.
//  Sub-module apb_slv_wait_ctr (load/decrement/zero flag) is instantiated only under
//   APB_SLV_WAIT_EN. Decode and the register bank stay in this file.
// TESTING
//  1 Reset high 2 cycles, then low:
//    - all outputs and ctrl_o read 0;
//    - a read of 0x0 returns 0, pslverr_o=0.
//  2 Write 0x0000_0005 to 0x0, then read 0x0:
//    - ctrl_o=5 the cycle after the write completes;
//    - read gives prdata_o=5;
//    - with the macro on, each transfer's pready_o is low exactly 2 access cycles.
//  3 Connect the APB master:
//    - cmd_i=01 reads 0x0, then cmd_i=10 writes the incremented value;
//    - ctrl_o goes 5 -> 6 and the next read returns 6.
//  4 Write 0xFFFF_FFFF to 0xC (ID):
//    - pslverr_o=1 with pready_o;
//    - a re-read returns 0xA9B0_0001.
//  5 Read 0x10 (out of range) and read 0x2 (misaligned):
//    - both give pslverr_o=1, prdata_o=0;
//    - no register changes.
//  6 Write in progress with the macro on:
//    - drop psel_i, or assert reset, at the first wait cycle;
//    - the target register is unchanged and the FSM is back in IDLE.

Source files
------------

// File: rtl/apb_regfile_pkg.sv
// Shared types and constants for the APB register-file completer.
package apb_regfile_pkg;

   typedef enum logic {
      IDLE,
      ACCESS
   } state_t;

   localparam int unsigned APB_ADDR_W = 32;
   localparam int unsigned APB_DATA_W = 32;
   localparam int unsigned CTRL_IDX   = 0;

   localparam logic [APB_DATA_W-1:0] ID_VALUE_DEF = 32'hA9B0_0001;

endpackage

// File: rtl/apb_slv_wait_ctr.sv
// Wait-state down-counter: loads on the setup edge, decrements during ACCESS, flags zero.
module apb_slv_wait_ctr #(
   parameter int unsigned Width   = 2,
   parameter int unsigned LoadVal = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic load_i,
   input  logic dec_i,
   output logic zero_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = Width'(LoadVal);
      end else if (dec_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/apb_slave_regfile.sv
// APB3 completer with CTRL/scratch/ID register bank. Optional wait states when
// APB_SLV_WAIT_EN is defined.
module apb_slave_regfile
   import apb_regfile_pkg::*;
#(
   parameter int unsigned              NUM_REGS    = 4,
   parameter logic [APB_ADDR_W-1:0]    BASE_ADDR   = '0,
   parameter logic [APB_DATA_W-1:0]    ID_VALUE    = ID_VALUE_DEF,
   parameter int unsigned              WAIT_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  psel_i,
   input  logic                  penable_i,
   input  logic [APB_ADDR_W-1:0] paddr_i,
   input  logic                  pwrite_i,
   input  logic [APB_DATA_W-1:0] pwdata_i,
   output logic                  pready_o,
   output logic [APB_DATA_W-1:0] prdata_o,
   output logic                  pslverr_o,
   output logic [APB_DATA_W-1:0] ctrl_o
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   state_t                  state_q, state_d;
   logic                    write_q, write_d;
   logic                    err_q, err_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [APB_DATA_W-1:0]   wdata_q, wdata_d;
   logic [APB_DATA_W-1:0]   prdata_q, prdata_d;
   logic [APB_DATA_W-1:0]   regs_q [NUM_REGS];

   logic [APB_ADDR_W-1:0]   offset;
   logic [IDX_W-1:0]        idx_s;
   logic                    err_s;
   logic [APB_DATA_W-1:0]   rd_val;
   logic                    setup;
   logic                    in_access;
   logic                    cnt_zero;
   logic                    reg_we;

   assign offset    = paddr_i - BASE_ADDR;
   assign idx_s     = offset[IDX_W+1:2];
   assign err_s     = (paddr_i[1:0] != 2'b00)
                    | (offset >= APB_ADDR_W'(NUM_REGS * 4))
                    | (pwrite_i & (idx_s == IDX_W'(NUM_REGS - 1)));
   assign rd_val    = (idx_s == IDX_W'(NUM_REGS - 1)) ? ID_VALUE : regs_q[idx_s];
   assign setup     = (state_q == IDLE) & psel_i & ~penable_i;
   assign in_access = (state_q == ACCESS);

`ifdef APB_SLV_WAIT_EN
   localparam int unsigned CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   apb_slv_wait_ctr #(
      .Width   (CNT_W),
      .LoadVal (WAIT_CYCLES)
   ) u_wait_ctr (
      .clk    (clk),
      .reset  (reset),
      .load_i (setup),
      .dec_i  (in_access & psel_i & penable_i),
      .zero_o (cnt_zero)
   );
`else
   logic unused_wait_cycles;
   assign unused_wait_cycles = ^WAIT_CYCLES;
   assign cnt_zero = 1'b1;
`endif

   always_comb begin
      state_d  = state_q;
      write_d  = write_q;
      err_d    = err_q;
      idx_d    = idx_q;
      wdata_d  = wdata_q;
      prdata_d = prdata_q;
      reg_we   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (setup) begin
               state_d  = ACCESS;
               write_d  = pwrite_i;
               wdata_d  = pwdata_i;
               idx_d    = idx_s;
               err_d    = err_s;
               prdata_d = (!pwrite_i && !err_s) ? rd_val : '0;
            end
         end
         ACCESS: begin
            if (!psel_i) begin
               state_d = IDLE;
            end else if (penable_i && cnt_zero) begin
               reg_we  = write_q & ~err_q;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         write_q  <= 1'b0;
         err_q    <= 1'b0;
         idx_q    <= '0;
         wdata_q  <= '0;
         prdata_q <= '0;
      end else begin
         state_q  <= state_d;
         write_q  <= write_d;
         err_q    <= err_d;
         idx_q    <= idx_d;
         wdata_q  <= wdata_d;
         prdata_q <= prdata_d;
      end
   end

   // The last slot is the read-only ID and is never written; it stays at reset value.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else if (reg_we) begin
         for (int i = 0; i < NUM_REGS - 1; i++) begin
            if (idx_q == IDX_W'(i)) begin
               regs_q[i] <= wdata_q;
            end
         end
      end
   end

   // Gated by psel_i so an aborted transfer never shows a completion.
   assign pready_o  = in_access & psel_i & cnt_zero;
   assign pslverr_o = pready_o & err_q;
   assign prdata_o  = prdata_q;
   assign ctrl_o    = regs_q[CTRL_IDX];

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Self-checking bench for apb_slave_regfile: vector table plus scoreboard queue.
module tb_apb_slave_regfile;

`ifdef APB_SLV_WAIT_EN
   localparam int EXP_WAIT = 2;
`else
   localparam int EXP_WAIT = 0;
`endif

   logic        clk = 1'b0;
   logic        reset;
   logic        psel_i, penable_i, pwrite_i;
   logic [31:0] paddr_i, pwdata_i;
   logic        pready_o, pslverr_o;
   logic [31:0] prdata_o, ctrl_o;

   int n_vec  = 0;
   int n_fail = 0;

   apb_slave_regfile dut (
      .clk       (clk),
      .reset     (reset),
      .psel_i    (psel_i),
      .penable_i (penable_i),
      .paddr_i   (paddr_i),
      .pwrite_i  (pwrite_i),
      .pwdata_i  (pwdata_i),
      .pready_o  (pready_o),
      .prdata_o  (prdata_o),
      .pslverr_o (pslverr_o),
      .ctrl_o    (ctrl_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic        wr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [31:0] exp_ctrl;
   } vec_t;

   typedef struct {
      string       name;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   exp_t sb[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Called just after a rising edge; returns just after the completion edge.
   task automatic apb_xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                           output logic [31:0] rd, output logic er, output int waits,
                           output logic timeout);
      psel_i = 1'b1; penable_i = 1'b0; paddr_i = addr; pwrite_i = wr; pwdata_i = wd;
      @(posedge clk); #1;
      penable_i = 1'b1;
      waits = 0; timeout = 1'b1; rd = '0; er = 1'b0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (pready_o) begin
            rd = prdata_o; er = pslverr_o; timeout = 1'b0;
            break;
         end
         waits++;
      end
      @(posedge clk); #1;
      psel_i = 1'b0; penable_i = 1'b0;
   endtask

   task automatic do_vec(input string name, input logic [31:0] addr, input logic wr,
                         input logic [31:0] wd, input logic [31:0] exp_rd, input logic exp_er);
      exp_t        e;
      logic [31:0] rd;
      logic        er, to;
      int          w;
      sb.push_back('{name: name, rdata: exp_rd, err: exp_er, waits: EXP_WAIT});
      apb_xfer(addr, wr, wd, rd, er, w, to);
      e = sb.pop_front();
      check({e.name, " timeout"}, {31'b0, to}, 32'd0);
      check({e.name, " prdata"}, rd, e.rdata);
      check({e.name, " pslverr"}, {31'b0, er}, {31'b0, e.err});
      check({e.name, " waits"}, 32'(w), 32'(e.waits));
   endtask

   vec_t vecs[16];

   initial begin
      logic [31:0] rd, val;
      logic        er, to;
      int          w;

      vecs[0]  = '{"rd0_init",   32'h0,  1'b0, 32'h0,         32'h0,         1'b0, 32'h0};
      vecs[1]  = '{"wr0_5",      32'h0,  1'b1, 32'h5,         32'h0,         1'b0, 32'h5};
      vecs[2]  = '{"rd0_5",      32'h0,  1'b0, 32'h0,         32'h5,         1'b0, 32'h5};
      vecs[3]  = '{"wr4",        32'h4,  1'b1, 32'hDEADBEEF,  32'h0,         1'b0, 32'h5};
      vecs[4]  = '{"wr8",        32'h8,  1'b1, 32'h12345678,  32'h0,         1'b0, 32'h5};
      vecs[5]  = '{"rd4",        32'h4,  1'b0, 32'h0,         32'hDEADBEEF,  1'b0, 32'h5};
      vecs[6]  = '{"rd8",        32'h8,  1'b0, 32'h0,         32'h12345678,  1'b0, 32'h5};
      vecs[7]  = '{"rd_id",      32'hC,  1'b0, 32'h0,         32'hA9B00001,  1'b0, 32'h5};
      vecs[8]  = '{"wr_id",      32'hC,  1'b1, 32'hFFFFFFFF,  32'h0,         1'b1, 32'h5};
      vecs[9]  = '{"rd_id_again",32'hC,  1'b0, 32'h0,         32'hA9B00001,  1'b0, 32'h5};
      vecs[10] = '{"rd_oor",     32'h10, 1'b0, 32'h0,         32'h0,         1'b1, 32'h5};
      vecs[11] = '{"rd_misal",   32'h2,  1'b0, 32'h0,         32'h0,         1'b1, 32'h5};
      vecs[12] = '{"wr_misal",   32'h6,  1'b1, 32'h1111,      32'h0,         1'b1, 32'h5};
      vecs[13] = '{"wr_oor",     32'h14, 1'b1, 32'h2222,      32'h0,         1'b1, 32'h5};
      vecs[14] = '{"rd4_keep",   32'h4,  1'b0, 32'h0,         32'hDEADBEEF,  1'b0, 32'h5};
      vecs[15] = '{"rd8_keep",   32'h8,  1'b0, 32'h0,         32'h12345678,  1'b0, 32'h5};

      reset = 1'b1; psel_i = 1'b0; penable_i = 1'b0; pwrite_i = 1'b0;
      paddr_i = '0; pwdata_i = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset pready",  {31'b0, pready_o},  32'd0);
      check("reset pslverr", {31'b0, pslverr_o}, 32'd0);
      check("reset prdata",  prdata_o, 32'd0);
      check("reset ctrl",    ctrl_o,   32'd0);
      @(posedge clk); #1;

      foreach (vecs[i]) begin
         do_vec(vecs[i].name, vecs[i].addr, vecs[i].wr, vecs[i].wdata,
                vecs[i].exp_rdata, vecs[i].exp_err);
         check({vecs[i].name, " ctrl"}, ctrl_o, vecs[i].exp_ctrl);
      end

      // Master-style read-modify-write of CTRL, back to back.
      apb_xfer(32'h0, 1'b0, 32'h0, val, er, w, to);
      check("rmw read", val, 32'h5);
      do_vec("rmw write", 32'h0, 1'b1, val + 32'd1, 32'h0, 1'b0);
      check("rmw ctrl", ctrl_o, 32'h6);
      do_vec("rmw reread", 32'h0, 1'b0, 32'h0, 32'h6, 1'b0);

      // Abort: psel_i drops in the first ACCESS cycle of a write.
      psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h4; pwrite_i = 1'b1; pwdata_i = 32'hAAAA;
      @(posedge clk); #1;
      psel_i = 1'b0;
      @(negedge clk);
      check("abort pready", {31'b0, pready_o}, 32'd0);
      @(posedge clk); #1;
      do_vec("abort rd4", 32'h4, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);

      // Reset in the first ACCESS cycle of a write to CTRL.
      psel_i = 1'b1; penable_i = 1'b0; paddr_i = 32'h0; pwrite_i = 1'b1; pwdata_i = 32'h77;
      @(posedge clk); #1;
      penable_i = 1'b1; reset = 1'b1;
      @(negedge clk);
      check("rst mid pready", {31'b0, pready_o}, 32'd0);
      check("rst mid ctrl",   ctrl_o, 32'd0);
      psel_i = 1'b0; penable_i = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      check("post rst ctrl", ctrl_o, 32'd0);
      do_vec("post rst rd0", 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
      do_vec("post rst rd4", 32'h4, 1'b0, 32'h0, 32'h0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
